// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS checker. A Fibonacci LFSR self-synchronises to the
// incoming bit stream, then predicts every following bit. Mismatches are
// flagged and counted, and lock is dropped and re-acquired on sustained errors.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bit_in     received serial bit
//   bit_valid  bit_in is sampled only on edges where this is 1
//   clear_cnt  synchronous clear of err_count and bit_count
//   locked     checker is synchronised
//   error      one-cycle pulse per mismatched bit while locked
//   err_count  mismatches counted while locked (saturating)
//   bit_count  valid bits checked while locked (saturating)
module prbs_checker #(
  parameter int unsigned           WIDTH       = 7,
  parameter logic [WIDTH-1:0]      POLY        = 7'b1100000,
  parameter int unsigned           LOCK_COUNT  = 16,
  parameter int unsigned           UNLOCK_ERRS = 4,
  parameter int unsigned           CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W   = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(UNLOCK_ERRS - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   s;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [BAD_W-1:0]   bad_cnt;
  logic               p;
  logic               mismatch;

  // Prediction comes from the register before this edge's shift.
  always_comb begin
    p        = ^(s & POLY);
    mismatch = (bit_in != p);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      s         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      if (bit_valid) begin
        case (state)
          SEARCH: begin
            s <= {s[WIDTH-2:0], bit_in};
            if (fill_cnt != FILL_MAX) begin
              fill_cnt <= fill_cnt + 1'b1;
            end else if (!mismatch && (s != '0)) begin
              // The all-zero guard keeps a dead (all-zero) line from locking.
              if (match_cnt == MATCH_LAST) begin
                state     <= LOCKED;
                match_cnt <= '0;
                bad_cnt   <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run on our own prediction so line errors do not corrupt the
            // local sequence.
            s <= {s[WIDTH-2:0], p};
            if (mismatch) begin
              error <= 1'b1;
              if (bad_cnt == BAD_LAST) begin
                state     <= SEARCH;
                fill_cnt  <= '0;
                match_cnt <= '0;
                bad_cnt   <= '0;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (clear_cnt) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (bit_valid && (state == LOCKED)) begin
      if (bit_count != '1) begin
        bit_count <= bit_count + 1'b1;
      end
      if (mismatch && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker. A reference PRBS7
// generator (x^7+x^6+1, seed 7'h01) drives the line; errors are injected by
// inverting individual bits. Expected values are fixed constants.
module tb_prbs_checker;

  logic        clk;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic [15:0] bit_count;

  int unsigned checks;
  int unsigned failures;
  int unsigned pulses;
  logic        seen_lock;
  logic [6:0]  g;

  prbs_checker #(
    .WIDTH      (7),
    .POLY       (7'b1100000),
    .LOCK_COUNT (16),
    .UNLOCK_ERRS(4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .error    (error),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Next bit of the reference generator.
  task automatic next_prbs(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  // Drive one cycle, sample #1 after the rising edge and tally observations.
  task automatic send(input logic b, input logic v, input logic clr);
    bit_in    = b;
    bit_valid = v;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    if (error) pulses++;
    if (locked) seen_lock = 1'b1;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic clean(input int unsigned n);
    logic b;
    for (int unsigned i = 0; i < n; i++) begin
      next_prbs(b);
      send(b, 1'b1, 1'b0);
    end
  endtask

  task automatic inject(input int unsigned n, input logic clr);
    logic b;
    for (int unsigned i = 0; i < n; i++) begin
      next_prbs(b);
      send(~b, 1'b1, clr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    g         = 7'h01;
    pulses    = 0;
    seen_lock = 1'b0;
  endtask

  initial begin
    logic b;
    checks    = 0;
    failures  = 0;
    pulses    = 0;
    seen_lock = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    g         = 7'h01;
    reset     = 1'b0;
    #1;
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_err_count", {16'd0, err_count}, 0);
    check("rst_bit_count", {16'd0, bit_count}, 0);

    // Clean stream: lock on the 23rd valid bit, then 200 checked bits.
    do_reset();
    clean(22);
    check("clean_nolock_22", {31'd0, locked}, 0);
    clean(1);
    check("clean_lock_23", {31'd0, locked}, 1);
    clean(200);
    check("clean_err_count", {16'd0, err_count}, 0);
    check("clean_bit_count", {16'd0, bit_count}, 200);
    check("clean_pulses", pulses, 0);

    // Single inverted bit at position 100 of this segment.
    clean(99);
    inject(1, 1'b0);
    check("single_error_pulse", {31'd0, error}, 1);
    check("single_err_count", {16'd0, err_count}, 1);
    check("single_bit_count", {16'd0, bit_count}, 300);
    check("single_locked", {31'd0, locked}, 1);
    clean(1);
    check("single_pulse_width", {31'd0, error}, 0);
    clean(50);
    check("single_pulses_total", pulses, 1);
    check("single_err_hold", {16'd0, err_count}, 1);

    // Clear on an idle edge, then four consecutive errors drop lock.
    send(1'b0, 1'b0, 1'b1);
    check("clear_idle_err", {16'd0, err_count}, 0);
    check("clear_idle_bits", {16'd0, bit_count}, 0);
    pulses = 0;
    inject(3, 1'b0);
    check("burst_locked_3", {31'd0, locked}, 1);
    inject(1, 1'b0);
    check("burst_unlock_4", {31'd0, locked}, 0);
    check("burst_err_count", {16'd0, err_count}, 4);
    check("burst_pulses", pulses, 4);
    clean(22);
    check("relock_not_yet", {31'd0, locked}, 0);
    clean(1);
    check("relock_23", {31'd0, locked}, 1);
    check("relock_err_hold", {16'd0, err_count}, 4);
    check("relock_bits_hold", {16'd0, bit_count}, 4);

    // bit_valid gaps freeze everything.
    do_reset();
    for (int unsigned i = 0; i < 22; i++) begin
      next_prbs(b);
      send(b, 1'b1, 1'b0);
      send(~b, 1'b0, 1'b0);
    end
    check("gap_nolock_22", {31'd0, locked}, 0);
    next_prbs(b);
    send(b, 1'b1, 1'b0);
    check("gap_lock_23", {31'd0, locked}, 1);
    for (int unsigned i = 0; i < 10; i++) begin
      next_prbs(b);
      send(b, 1'b1, 1'b0);
      send(~b, 1'b0, 1'b0);
    end
    check("gap_bit_count", {16'd0, bit_count}, 10);
    check("gap_pulses", pulses, 0);

    // Clear has priority over a simultaneous error increment.
    inject(1, 1'b1);
    check("clr_err_pulse", {31'd0, error}, 1);
    check("clr_err_count", {16'd0, err_count}, 0);
    check("clr_bit_count", {16'd0, bit_count}, 0);

    // Three spaced errors, then asynchronous reset mid-stream.
    for (int unsigned i = 0; i < 3; i++) begin
      clean(2);
      inject(1, 1'b0);
    end
    check("pre_rst_err_count", {16'd0, err_count}, 3);
    check("pre_rst_locked", {31'd0, locked}, 1);
    reset = 1'b0;
    #1;
    check("arst_locked", {31'd0, locked}, 0);
    check("arst_err_count", {16'd0, err_count}, 0);
    check("arst_error", {31'd0, error}, 0);
    #11;
    reset = 1'b1;
    clean(22);
    check("arst_relock_22", {31'd0, locked}, 0);
    clean(1);
    check("arst_relock_23", {31'd0, locked}, 1);

    // All-zero line never locks.
    do_reset();
    for (int unsigned i = 0; i < 500; i++) send(1'b0, 1'b1, 1'b0);
    check("zero_never_lock", {31'd0, seen_lock}, 0);
    check("zero_err_count", {16'd0, err_count}, 0);

    // Non-PRBS pattern 110 repeating never locks.
    do_reset();
    for (int unsigned i = 0; i < 300; i++) send((i % 3) != 2, 1'b1, 1'b0);
    check("pattern_never_lock", {31'd0, seen_lock}, 0);
    check("pattern_pulses", pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
